blob_centroid_tracker: RTL and testbench
========================================

BLOB_CENTROID_TRACKER -- requirements
Module: blob_centroid_tracker

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 320, active columns per frame.
REQ-002 SHALL have parameter V_ACTIVE, default 240, active rows per frame.
REQ-003 SHALL have parameter COORD_W, default 10, width of Hcnt/Vcnt/xpos/ypos.
REQ-004 SHALL have parameter SUM_W, default 32, width of coordinate accumulators and divider.
REQ-005 SHALL have parameter CNT_W, default 18, width of pixel-count accumulator.
REQ-006 SHALL have parameter MIN_PIXELS, default 64, minimum qualifying pixels for a valid blob.
REQ-007 SHALL have port clock, input, 1, sole clock, all logic on rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have ports R, G, B, input, 8 each, pixel colour.
REQ-010 SHALL have port ActiveArea, input, 1, pixel valid this cycle.
REQ-011 SHALL have ports Hcnt, Vcnt, input, COORD_W each, pixel column/row.
REQ-012 SHALL have ports thr_lo, thr_hi, input, 8 each, exclusive bounds on R-G.
REQ-013 SHALL have port mask, output, 1, registered per-pixel qualify flag.
REQ-014 SHALL have ports xpos, ypos, output, COORD_W each, last blob centroid.
REQ-015 SHALL have port found, output, 1, last completed frame met MIN_PIXELS.
REQ-016 SHALL have port pos_valid, output, 1, one-cycle pulse when xpos/ypos/found update.
REQ-017 SHALL have ports busy, output, 1, divider running; frame_drop, output, 1, one-cycle pulse on lost frame.

Function
REQ-018 SHALL qualify a pixel when ActiveArea=1, Hcnt<H_ACTIVE, Vcnt<V_ACTIVE, R>G and thr_lo < (R-G) < thr_hi (unsigned 8-bit difference).
REQ-019 SHALL register mask one cycle after the pixel; mask=0 for non-qualifying or inactive pixels.
REQ-020 SHALL, per qualifying pixel, add Hcnt to sum_x, Vcnt to sum_y, 1 to count; sums/count saturate at all-ones, never wrap.
REQ-021 SHALL detect frame end as the cycle ActiveArea=1, Hcnt=H_ACTIVE-1, Vcnt=V_ACTIVE-1; that pixel is included.
REQ-022 SHALL at frame end snapshot sum_x, sum_y, count into divider operands and clear accumulators next cycle, so the following frame starts at zero with no lost pixel.
REQ-023 SHALL implement FSM IDLE, DIV, DONE; reset state IDLE.
REQ-024 SHALL, IDLE + frame end with count >= MIN_PIXELS, go to DIV with busy=1.
REQ-025 SHALL, IDLE + frame end with count < MIN_PIXELS (incl. 0), go to DONE without dividing: found<=0, xpos/ypos hold.
REQ-026 SHALL in DIV run restoring division, one quotient bit per cycle, sum_x/count and sum_y/count in parallel, exactly SUM_W cycles, then go to DONE.
REQ-027 SHALL in DONE, for one cycle, load xpos/ypos with truncated quotients' low COORD_W bits (divided path), set found accordingly, assert pos_valid, clear busy, return to IDLE.
REQ-028 SHALL give latency frame end -> pos_valid of SUM_W+2 cycles (divided) or 2 cycles (skipped).
REQ-029 SHALL, on frame end while in DIV or DONE, discard that frame's snapshot, pulse frame_drop, continue current division unaffected; accumulators still clear.
REQ-030 SHALL keep xpos, ypos, found stable except in the DONE cycle.
REQ-031 SHALL change thr_lo/thr_hi effect from the next pixel; no frame resync.

Reset
REQ-032 SHALL on reset clear mask, xpos, ypos, found, pos_valid, busy, frame_drop, accumulators, divider registers; FSM to IDLE.
REQ-033 SHALL on reset during DIV abort the division with no pos_valid pulse.

Verification
REQ-034 Frame with 8x8 qualifying square cols 100-107, rows 50-57 (R=100,G=60,thr 10/74) -> after SUM_W+2 cycles pos_valid=1, xpos=103, ypos=53, found=1.
REQ-035 Frame with 10 qualifying pixels (MIN_PIXELS=64) -> pos_valid 2 cycles after frame end, found=0, xpos/ypos unchanged.
REQ-036 R-G equal to thr_lo or thr_hi, or G>R -> mask=0, not counted.
REQ-037 Shortened frames with frame end while busy=1 -> frame_drop pulse, first result correct, no second pos_valid.
REQ-038 reset mid-DIV -> all outputs 0 next cycle, no pos_valid; next full frame produces correct centroid.
REQ-039 Qualifying pixels at Hcnt>=H_ACTIVE or ActiveArea=0 -> not counted; centroid unchanged.

Source files
------------

// File: rtl/blob_centroid_tracker.sv
// Colour-threshold blob tracker: qualifies pixels on R-G, accumulates coordinates, divides for the centroid.
// Latency: mask 1 cycle; pos_valid SUM_W+2 cycles after frame end (divided) or 2 cycles (too few pixels).
// Backpressure: none on the pixel stream; a frame ending while the divider is busy is dropped with frame_drop.
module blob_centroid_tracker #(
    parameter int H_ACTIVE   = 320,
    parameter int V_ACTIVE   = 240,
    parameter int COORD_W    = 10,
    parameter int SUM_W      = 32,
    parameter int CNT_W      = 18,
    parameter int MIN_PIXELS = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         R,
    input  logic [7:0]         G,
    input  logic [7:0]         B,
    input  logic               ActiveArea,
    input  logic [COORD_W-1:0] Hcnt,
    input  logic [COORD_W-1:0] Vcnt,
    input  logic [7:0]         thr_lo,
    input  logic [7:0]         thr_hi,
    output logic               mask,
    output logic [COORD_W-1:0] xpos,
    output logic [COORD_W-1:0] ypos,
    output logic               found,
    output logic               pos_valid,
    output logic               busy,
    output logic               frame_drop
);

    localparam int                 SW1      = SUM_W + 1;
    localparam int                 BIT_W    = $clog2(SUM_W + 1);
    localparam logic [31:0]        H_LIM    = H_ACTIVE;
    localparam logic [31:0]        V_LIM    = V_ACTIVE;
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0]   MIN_CNT  = CNT_W'(MIN_PIXELS);
    localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(SUM_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [7:0]       diff;
    logic             qualify;
    logic             frame_end;
    logic             take;
    logic [SUM_W-1:0] sum_x, sum_y, sum_x_nxt, sum_y_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [SW1-1:0]   add_x, add_y;

    logic [SUM_W-1:0] dvd_x, dvd_y, rem_x, rem_y, divisor;
    logic [SW1-1:0]   sh_x, sh_y, sub_x, sub_y;
    logic             ge_x, ge_y;
    logic [BIT_W-1:0] bit_cnt;
    logic             divided;
    logic             unused_bits;

    assign unused_bits = ^{B, sub_x[SUM_W], sub_y[SUM_W]};

    // Pixel qualification and saturating accumulation; the frame-end pixel is folded into the *_nxt values
    always_comb begin
        diff      = R - G;
        qualify   = ActiveArea && (32'(Hcnt) < H_LIM) && (32'(Vcnt) < V_LIM) &&
                    (R > G) && (diff > thr_lo) && (diff < thr_hi);
        frame_end = ActiveArea && (Hcnt == H_LAST) && (Vcnt == V_LAST);
        add_x     = {1'b0, sum_x} + SW1'(Hcnt);
        add_y     = {1'b0, sum_y} + SW1'(Vcnt);
        sum_x_nxt = sum_x;
        sum_y_nxt = sum_y;
        count_nxt = count;
        if (qualify) begin
            sum_x_nxt = add_x[SUM_W] ? '1 : add_x[SUM_W-1:0];
            sum_y_nxt = add_y[SUM_W] ? '1 : add_y[SUM_W-1:0];
            if (count != '1) begin
                count_nxt = count + CNT_W'(1);
            end
        end
        take = (count_nxt >= MIN_CNT);
    end

    // One restoring-division step per axis: dividend shifts out MSB-first, quotient shifts in at the LSB
    always_comb begin
        sh_x  = {rem_x, dvd_x[SUM_W-1]};
        sh_y  = {rem_y, dvd_y[SUM_W-1]};
        sub_x = sh_x - {1'b0, divisor};
        sub_y = sh_y - {1'b0, divisor};
        ge_x  = (sh_x >= {1'b0, divisor});
        ge_y  = (sh_y >= {1'b0, divisor});
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (frame_end) begin
                    state_d = take ? DIV : DONE;
                end
            end
            DIV: begin
                if (bit_cnt == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mask       <= 1'b0;
            xpos       <= '0;
            ypos       <= '0;
            found      <= 1'b0;
            pos_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_drop <= 1'b0;
            sum_x      <= '0;
            sum_y      <= '0;
            count      <= '0;
            dvd_x      <= '0;
            dvd_y      <= '0;
            rem_x      <= '0;
            rem_y      <= '0;
            divisor    <= '0;
            bit_cnt    <= '0;
            divided    <= 1'b0;
        end else begin
            mask       <= qualify;
            pos_valid  <= 1'b0;
            frame_drop <= frame_end && (state_q != IDLE);

            // Accumulators restart at zero whether or not the snapshot is taken
            if (frame_end) begin
                sum_x <= '0;
                sum_y <= '0;
                count <= '0;
            end else begin
                sum_x <= sum_x_nxt;
                sum_y <= sum_y_nxt;
                count <= count_nxt;
            end

            case (state_q)
                IDLE: begin
                    if (frame_end) begin
                        dvd_x   <= sum_x_nxt;
                        dvd_y   <= sum_y_nxt;
                        divisor <= SUM_W'(count_nxt);
                        rem_x   <= '0;
                        rem_y   <= '0;
                        bit_cnt <= '0;
                        divided <= take;
                        busy    <= take;
                    end
                end
                DIV: begin
                    dvd_x   <= {dvd_x[SUM_W-2:0], ge_x};
                    dvd_y   <= {dvd_y[SUM_W-2:0], ge_y};
                    rem_x   <= ge_x ? sub_x[SUM_W-1:0] : sh_x[SUM_W-1:0];
                    rem_y   <= ge_y ? sub_y[SUM_W-1:0] : sh_y[SUM_W-1:0];
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
                DONE: begin
                    pos_valid <= 1'b1;
                    busy      <= 1'b0;
                    found     <= divided;
                    if (divided) begin
                        xpos <= dvd_x[COORD_W-1:0];
                        ypos <= dvd_y[COORD_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_blob_centroid_tracker.sv
// Directed bench for blob_centroid_tracker with a result scoreboard keyed on expected pos_valid cycle.
module tb_blob_centroid_tracker;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] R, G, B;
    logic       ActiveArea;
    logic [9:0] Hcnt, Vcnt;
    logic [7:0] thr_lo, thr_hi;
    logic       mask;
    logic [9:0] xpos, ypos;
    logic       found, pos_valid, busy, frame_drop;

    blob_centroid_tracker dut (
        .clock(clock), .reset(reset), .R(R), .G(G), .B(B),
        .ActiveArea(ActiveArea), .Hcnt(Hcnt), .Vcnt(Vcnt),
        .thr_lo(thr_lo), .thr_hi(thr_hi), .mask(mask),
        .xpos(xpos), .ypos(ypos), .found(found), .pos_valid(pos_valid),
        .busy(busy), .frame_drop(frame_drop)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic       f;
        logic [9:0] x;
        logic [9:0] y;
    } res_t;

    res_t res_q[$];
    int   drop_q[$];

    int         errors = 0;
    int         checks = 0;
    longint     msx, msy;
    int         mcnt;
    logic [9:0] last_x, last_y;
    int         last_due;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic qual(input logic [7:0] r, g, input logic act, input int h, v,
                                  input logic [7:0] lo, hi);
        logic [7:0] d;
        d = r - g;
        return act && (h < 320) && (v < 240) && (r > g) && (d > lo) && (d < hi);
    endfunction

    // Drive one pixel for one cycle, update the reference model, check mask a cycle later
    task automatic pix(input logic [7:0] r, g, input logic act, input int h, v);
        logic em;
        int   p;
        res_t e;
        R = r; G = g; B = 8'h55; ActiveArea = act; Hcnt = 10'(h); Vcnt = 10'(v);
        em = qual(r, g, act, h, v, thr_lo, thr_hi);
        if (em) begin
            msx += h; msy += v; mcnt++;
        end
        if (act && h == 319 && v == 239) begin
            p = cyc;
            if (p < last_due) begin
                drop_q.push_back(p + 1);
            end else begin
                if (mcnt >= 64) begin
                    last_x = 10'(msx / mcnt);
                    last_y = 10'(msy / mcnt);
                    e = '{p + 34, 1'b1, last_x, last_y};
                end else begin
                    e = '{p + 2, 1'b0, last_x, last_y};
                end
                res_q.push_back(e);
                last_due = e.due;
            end
            msx = 0; msy = 0; mcnt = 0;
        end
        @(negedge clock);
        check("mask", mask, em);
        ActiveArea = 1'b0;
    endtask

    task automatic square();
        for (int r = 50; r < 58; r++)
            for (int c = 100; c < 108; c++)
                pix(8'd100, 8'd60, 1'b1, c, r);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (res_q.size() == 0 && drop_q.size() == 0) break;
            @(negedge clock);
        end
        check("drain_timeout", res_q.size() + drop_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mask"}, mask, 0);
        check({tag, "_xpos"}, xpos, 0);
        check({tag, "_ypos"}, ypos, 0);
        check({tag, "_found"}, found, 0);
        check({tag, "_pos_valid"}, pos_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_drop"}, frame_drop, 0);
    endtask

    always @(negedge clock) begin
        res_t e;
        int   d;
        if (pos_valid) begin
            if (res_q.size() == 0) begin
                check("spurious_pos_valid", pos_valid, 0);
            end else begin
                e = res_q.pop_front();
                check("pv_cycle", cyc, e.due);
                check("found", found, e.f);
                check("xpos", xpos, e.x);
                check("ypos", ypos, e.y);
            end
        end
        if (frame_drop) begin
            if (drop_q.size() == 0) begin
                check("spurious_frame_drop", frame_drop, 0);
            end else begin
                d = drop_q.pop_front();
                check("drop_cycle", cyc, d);
            end
        end
    end

    initial begin
        reset = 1'b1; R = 0; G = 0; B = 0; ActiveArea = 0; Hcnt = 0; Vcnt = 0;
        thr_lo = 8'd10; thr_hi = 8'd74;
        msx = 0; msy = 0; mcnt = 0; last_x = 0; last_y = 0; last_due = 0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        // Square centroid; qualifying colours outside the active window are ignored
        pix(8'd100, 8'd60, 1'b0, 100, 50);
        pix(8'd100, 8'd60, 1'b1, 320, 50);
        pix(8'd100, 8'd60, 1'b1, 100, 240);
        square();
        pix(8'd0, 8'd0, 1'b1, 319, 239);
        check("busy_during_div", busy, 1);
        drain();
        check("busy_after_done", busy, 0);

        // Too few pixels plus threshold boundaries and a mid-frame threshold change
        for (int i = 1; i <= 10; i++) pix(8'd100, 8'd60, 1'b1, i, 3);
        pix(8'd70, 8'd60, 1'b1, 20, 3);
        pix(8'd134, 8'd60, 1'b1, 21, 3);
        thr_hi = 8'd255;
        pix(8'd60, 8'd100, 1'b1, 22, 3);
        pix(8'd200, 8'd60, 1'b1, 23, 3);
        thr_hi = 8'd74;
        pix(8'd200, 8'd60, 1'b1, 24, 3);
        pix(8'd0, 8'd0, 1'b1, 319, 239);
        drain();

        // Qualifying frame-end pixel is counted; a short frame during the division is dropped
        for (int i = 0; i < 63; i++) pix(8'd100, 8'd60, 1'b1, 300, 200);
        pix(8'd100, 8'd60, 1'b1, 319, 239);
        for (int i = 0; i < 5; i++) pix(8'd100, 8'd60, 1'b1, 10, 20);
        pix(8'd0, 8'd0, 1'b1, 319, 239);
        drain();
        for (int i = 0; i < 64; i++) pix(8'd100, 8'd60, 1'b1, 40, 30);
        pix(8'd0, 8'd0, 1'b1, 319, 239);
        drain();

        // Reset in the middle of a division
        for (int i = 0; i < 64; i++) pix(8'd100, 8'd60, 1'b1, 200, 100);
        pix(8'd0, 8'd0, 1'b1, 319, 239);
        repeat (10) @(negedge clock);
        check("busy_before_abort", busy, 1);
        res_q.delete();
        drop_q.delete();
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("abort");
        reset = 1'b0;
        msx = 0; msy = 0; mcnt = 0; last_x = 0; last_y = 0; last_due = 0;
        repeat (40) @(negedge clock);

        // Empty frame, then a full centroid again
        pix(8'd0, 8'd0, 1'b1, 319, 239);
        drain();
        square();
        pix(8'd0, 8'd0, 1'b1, 319, 239);
        drain();
        repeat (5) @(negedge clock);
        check("left_results", res_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
